// File: rtl/link_pkg.sv
// Shared definitions for the host-link transmit path: framing constants, state encodings and
// the running checksum helper.
package link_pkg;

    localparam logic [7:0]  HDR0      = 8'hAA;
    localparam logic [7:0]  HDR1      = 8'h55;
    localparam int unsigned FRAME_LEN = 44;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWait,
        StFetch,
        StLatch,
        StFinish
    } frame_state_e;

    typedef enum logic [1:0] {
        PcIdle,
        PcSend,
        PcWaitHi,
        PcWaitLo
    } pacer_state_e;

    function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] b);
        return chk ^ b;
    endfunction

endpackage

// File: rtl/tx_byte_pacer.sv
// Single-byte handshake with uart_tx: waits for the UART to be free, strobes the byte once,
// then waits for the busy pulse (or a short timeout) and its release before reporting done.
module tx_byte_pacer
    import link_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       tx_busy,
    output logic       accept,
    output logic       byte_done,
    output logic [7:0] tx_data,
    output logic       tx_send
);

    pacer_state_e state_q, state_d;
    logic [7:0]   data_q;
    logic [1:0]   cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= PcIdle;
            data_q  <= 8'h00;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            // tx_data only moves while the UART is idle and no strobe is pending
            if (accept) data_q <= byte_in;
            if (state_q == PcSend) cnt_q <= 2'd0;
            else if (state_q == PcWaitHi) cnt_q <= cnt_q + 2'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        byte_done = 1'b0;
        case (state_q)
            PcIdle: begin
                accept = byte_valid && !tx_busy;
                if (accept) state_d = PcSend;
            end
            PcSend: state_d = PcWaitHi;
            PcWaitHi: begin
                // a UART that never raises busy must not stall the frame
                if (tx_busy || cnt_q == 2'd3) state_d = PcWaitLo;
            end
            PcWaitLo: begin
                if (!tx_busy) begin
                    byte_done = 1'b1;
                    state_d   = PcIdle;
                end
            end
            default: state_d = PcIdle;
        endcase
    end

    assign tx_data = data_q;
    assign tx_send = (state_q == PcSend);

endmodule

// File: rtl/score_packet_tx.sv
// Frame sequencer: header, digit, all class scores LSB first, then an XOR checksum over the
// digit and score bytes, paced one byte at a time through tx_byte_pacer.
module score_packet_tx #(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned SCORE_W     = 32,
    parameter logic [7:0]  HDR0        = link_pkg::HDR0,
    parameter logic [7:0]  HDR1        = link_pkg::HDR1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         digit,
    output logic [3:0]         score_addr,
    input  logic [SCORE_W-1:0] score_data,
    output logic [7:0]         tx_data,
    output logic               tx_send,
    input  logic               tx_busy,
    output logic               busy,
    output logic               done
);
    import link_pkg::*;

    localparam int unsigned  BYTES   = SCORE_W / 8;
    localparam int unsigned  SBW     = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [SBW-1:0] SB_LAST = SBW'(BYTES - 1);
    localparam logic [3:0]   NC      = 4'(NUM_CLASSES);

    frame_state_e       state_q, state_d;
    logic [3:0]         digit_q;
    logic [7:0]         chk_q;
    logic [1:0]         idx_q;        // 0 HDR0, 1 HDR1, 2 digit, 3 score/checksum phase
    logic               chk_phase_q;
    logic [SBW-1:0]     sb_q;
    logic [3:0]         class_q;
    logic [3:0]         addr_q;
    logic [SCORE_W-1:0] shreg_q;

    logic [7:0] cur_byte;
    logic       accept, byte_done, byte_valid;
    logic       last_score_byte, need_fetch, score_more, to_chk;

    always_comb begin
        cur_byte = shreg_q[7:0];
        case (idx_q)
            2'd0:    cur_byte = HDR0;
            2'd1:    cur_byte = HDR1;
            2'd2:    cur_byte = {4'h0, digit_q};
            default: cur_byte = chk_phase_q ? chk_q : shreg_q[7:0];
        endcase
    end

    assign last_score_byte = (idx_q == 2'd3) && !chk_phase_q && (sb_q == SB_LAST);
    assign score_more      = (idx_q == 2'd3) && !chk_phase_q && (sb_q != SB_LAST);
    assign need_fetch      = (idx_q == 2'd2) || (last_score_byte && class_q < NC);
    assign to_chk          = last_score_byte && !(class_q < NC);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            digit_q     <= 4'h0;
            chk_q       <= 8'h00;
            idx_q       <= 2'd0;
            chk_phase_q <= 1'b0;
            sb_q        <= '0;
            class_q     <= 4'h0;
            addr_q      <= 4'h0;
            shreg_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: if (start) begin
                    digit_q     <= digit;
                    chk_q       <= 8'h00;
                    idx_q       <= 2'd0;
                    chk_phase_q <= 1'b0;
                    class_q     <= 4'h0;
                end
                StSend: if (accept && idx_q >= 2'd2 && !chk_phase_q) begin
                    chk_q <= chk_update(chk_q, cur_byte);
                end
                StWait: if (byte_done) begin
                    if (idx_q != 2'd3) idx_q <= idx_q + 2'd1;
                    if (score_more) begin
                        sb_q    <= sb_q + 1'b1;
                        shreg_q <= shreg_q >> 8;
                    end
                    if (to_chk) chk_phase_q <= 1'b1;
                    // address is presented for the whole FETCH cycle; data lands in LATCH
                    if (need_fetch && !chk_phase_q) addr_q <= class_q;
                end
                StLatch: begin
                    shreg_q <= score_data;
                    class_q <= class_q + 4'h1;
                    sb_q    <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start) state_d = StSend;
            StSend:   if (accept) state_d = StWait;
            StWait: begin
                if (byte_done) begin
                    if (chk_phase_q)     state_d = StFinish;
                    else if (need_fetch) state_d = StFetch;
                    else                 state_d = StSend;
                end
            end
            StFetch:  state_d = StLatch;
            StLatch:  state_d = StSend;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    assign byte_valid = (state_q == StSend);
    assign busy       = (state_q != StIdle) && (state_q != StFinish);
    assign done       = (state_q == StFinish);
    assign score_addr = addr_q;

    tx_byte_pacer u_pacer (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_in    (cur_byte),
        .byte_valid (byte_valid),
        .tx_busy    (tx_busy),
        .accept     (accept),
        .byte_done  (byte_done),
        .tx_data    (tx_data),
        .tx_send    (tx_send)
    );

endmodule

// File: tb/tb_score_packet_tx.sv
// Scoreboard bench for score_packet_tx with a simple uart_tx busy model and score storage.
module tb_score_packet_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  digit;
    logic [3:0]  score_addr;
    logic [31:0] score_data;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_busy;
    logic        busy;
    logic        done;

    logic [31:0] scores [10];
    logic        never_busy;
    logic        ext_busy;
    int          busy_cnt;
    int          cyc;

    logic [7:0]  exp_q [$];
    logic [7:0]  cap [64];
    int          pos;
    int          strobes;
    int          done_cnt;
    int          first_cyc;
    int          n_tests;
    int          n_fail;

    score_packet_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .digit      (digit),
        .score_addr (score_addr),
        .score_data (score_data),
        .tx_data    (tx_data),
        .tx_send    (tx_send),
        .tx_busy    (tx_busy),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx model: busy for 20 cycles after each strobe unless configured never to assert
    always @(posedge clk) begin
        if (tx_send && !never_busy) busy_cnt <= 20;
        else if (busy_cnt != 0)     busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0) || ext_busy;

    always @(posedge clk) score_data <= (score_addr < 4'd10) ? scores[score_addr] : 32'h0;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every strobe and checks tx_data stability
    initial begin
        logic [7:0] held;
        logic       pend;
        logic [7:0] e;
        pend = 1'b0;
        held = 8'h00;
        forever begin
            @(negedge clk);
            if (pend) begin
                check("tx_data_stable", int'(tx_data), int'(held));
                pend = 1'b0;
            end
            if (tx_send) begin
                strobes++;
                held = tx_data;
                pend = 1'b1;
                if (pos == 0) first_cyc = cyc;
                if (pos < 64) cap[pos] = tx_data;
                pos++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got byte 0x%0h, expected no strobe", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_byte", int'(tx_data), int'(e));
                end
            end
            if (done) begin
                done_cnt++;
                check("busy_low_at_done", int'(busy), 0);
            end
        end
    end

    task automatic push_frame(input logic [3:0] d);
        logic [7:0] c;
        logic [7:0] b;
        logic [31:0] s;
        c = {4'h0, d};
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_q.push_back(c);
        for (int k = 0; k < 10; k++) begin
            s = scores[k];
            for (int j = 0; j < 4; j++) begin
                b = s[8*j +: 8];
                exp_q.push_back(b);
                c = c ^ b;
            end
        end
        exp_q.push_back(c);
    endtask

    task automatic pulse_start(input logic [3:0] d);
        @(negedge clk);
        digit = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        digit = 4'hF;
    endtask

    task automatic wait_done(input int max, input int snap);
        int n;
        n = 0;
        while (done_cnt == snap && n < max) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == snap) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", max);
        end
    endtask

    task automatic wait_pos(input int p, input int max);
        int n;
        n = 0;
        while (pos < p && n < max) begin
            @(negedge clk);
            n++;
        end
        check("reached_byte", pos >= p ? 1 : 0, 1);
    endtask

    task automatic run_frame(input string tag, input logic [3:0] d);
        int snap;
        snap = done_cnt;
        pos = 0;
        push_frame(d);
        pulse_start(d);
        check({tag, "_busy_after_start"}, int'(busy), 1);
        wait_done(6000, snap);
        @(negedge clk);
        check({tag, "_done_count"}, done_cnt - snap, 1);
        check({tag, "_byte_count"}, pos, 44);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int snap;
        int s_snap;
        int rel;
        cyc = 0;
        busy_cnt = 0;
        n_tests = 0;
        n_fail = 0;
        pos = 0;
        strobes = 0;
        done_cnt = 0;
        first_cyc = 0;
        never_busy = 1'b0;
        ext_busy = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        digit = 4'h0;
        for (int k = 0; k < 10; k++) scores[k] = 32'h0101_0101 * k;

        repeat (3) @(negedge clk);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_tx_send", int'(tx_send), 0);
        check("rst_score_addr", int'(score_addr), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: basic frame, equal-byte scores cancel in the checksum
        run_frame("t1", 4'd7);
        check("t1_digit_byte", int'(cap[2]), 8'h07);
        check("t1_chk", int'(cap[43]), 8'h07);

        // 2: negative score, LSB first
        scores[3] = 32'hFFFF_FF85;
        run_frame("t2", 4'd7);
        check("t2_off15", int'(cap[15]), 8'h85);
        check("t2_off16", int'(cap[16]), 8'hFF);
        check("t2_off17", int'(cap[17]), 8'hFF);
        check("t2_off18", int'(cap[18]), 8'hFF);
        check("t2_chk", int'(cap[43]), 8'h7D);
        scores[3] = 32'h0303_0303;

        // 3: start during a frame is ignored
        snap = done_cnt;
        pos = 0;
        push_frame(4'd7);
        pulse_start(4'd7);
        wait_pos(10, 2000);
        pulse_start(4'd2);
        wait_done(6000, snap);
        repeat (50) @(negedge clk);
        check("t3_done_count", done_cnt - snap, 1);
        check("t3_byte_count", pos, 44);
        check("t3_digit_byte", int'(cap[2]), 8'h07);

        // 4: reset mid-frame aborts silently, next frame is complete
        snap = done_cnt;
        pos = 0;
        push_frame(4'd7);
        pulse_start(4'd7);
        wait_pos(20, 2000);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        s_snap = strobes;
        repeat (300) @(negedge clk);
        check("t4_no_strobe_after_rst", strobes - s_snap, 0);
        check("t4_busy_after_rst", int'(busy), 0);
        check("t4_no_done", done_cnt - snap, 0);
        run_frame("t4b", 4'd5);
        check("t4b_digit_byte", int'(cap[2]), 8'h05);

        // 5: UART never raises busy, timeout path
        never_busy = 1'b1;
        s_snap = strobes;
        run_frame("t5", 4'd9);
        check("t5_strobes", strobes - s_snap, 44);
        never_busy = 1'b0;

        // 6: another UART user holds busy before start
        snap = done_cnt;
        pos = 0;
        ext_busy = 1'b1;
        s_snap = strobes;
        push_frame(4'd3);
        pulse_start(4'd3);
        repeat (100) @(negedge clk);
        check("t6_no_strobe_while_busy", strobes - s_snap, 0);
        ext_busy = 1'b0;
        rel = cyc;
        wait_done(6000, snap);
        @(negedge clk);
        check("t6_first_after_release", first_cyc >= rel ? 1 : 0, 1);
        check("t6_byte_count", pos, 44);
        check("t6_done_count", done_cnt - snap, 1);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
